serial_frame_rx: RTL and testbench



---
 rtl/serial_frame_pkg.sv | 22 ++
 rtl/serial_frame_rx_frame_shift.sv | 35 +++
 rtl/serial_frame_rx.sv | 136 +++++++++++++
 tb/tb_serial_frame_rx.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the sen/sd serial frame receiver.
// States, error codes and frame-length arithmetic.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WRITE,
        DRAIN,
        ERR_WAIT
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SHORT  = 2'b01;
    localparam logic [1:0] ERR_LONG   = 2'b10;
    localparam logic [1:0] ERR_PARITY = 2'b11;

    function automatic int frame_len(input int aw, input int dw, input int parity);
        return aw + dw + parity;
    endfunction

endpackage

// File: rtl/serial_frame_rx_frame_shift.sv
// MSB-first deserialiser: L-bit shift register with a bit counter.
// last flags L-1 bits held, full flags a complete frame.
module frame_shift #(
    parameter int L = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    output logic [L-1:0] frame,
    output logic         last,
    output logic         full
);

    localparam int CW = $clog2(L + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            frame <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            frame <= {frame[L-2:0], bit_in};
            cnt   <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(L - 1));
    assign full = (cnt == CW'(L));

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: deserialises sen/sd frames and writes the
// register bank, reporting framing/parity errors and address coverage.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int AW     = 3,
    parameter int DW     = 18,
    parameter int PARITY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sen,
    input  logic          sd,
    output logic          RB_RW,
    output logic [AW-1:0] RB_A,
    output logic [DW-1:0] RB_D,
    output logic          done,
    output logic          frame_err,
    output logic [1:0]    err_code
);

    localparam int L = frame_len(AW, DW, PARITY);
    localparam int N = 2 ** AW;

    state_t        state;
    state_t        state_nxt;
    logic [L-1:0]  frame;
    logic          last;
    logic          full;
    logic          en;
    logic          clr;
    logic          par_bad;
    logic [N-1:0]  map;
    logic          rw_nxt;
    logic [AW-1:0] a_nxt;
    logic [DW-1:0] d_nxt;
    logic          err_nxt;
    logic [1:0]    code_nxt;

    assign en  = !sen && (state == IDLE || state == SHIFT);
    assign clr = (state == SHIFT) ? sen : (state != IDLE);

    // parity over the frame as it will look once the incoming bit lands
    assign par_bad = (PARITY != 0) && (^{frame[L-2:0], sd});

    frame_shift #(.L(L)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .bit_in (sd),
        .frame  (frame),
        .last   (last),
        .full   (full)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (!sen) state_nxt = SHIFT;
            SHIFT: begin
                if (sen)       state_nxt = IDLE;
                else if (last) state_nxt = par_bad ? ERR_WAIT : WRITE;
            end
            WRITE:    state_nxt = sen ? IDLE : DRAIN;
            DRAIN:    if (sen) state_nxt = IDLE;
            ERR_WAIT: if (sen) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rw_nxt   = 1'b1;
        a_nxt    = RB_A;
        d_nxt    = RB_D;
        err_nxt  = 1'b0;
        code_nxt = ERR_NONE;
        unique case (state)
            SHIFT: begin
                if (sen) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_SHORT;
                end
            end
            WRITE: begin
                rw_nxt = 1'b0;
                a_nxt  = frame[L-1 -: AW];
                d_nxt  = frame[L-1-AW -: DW];
                if (!sen) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_LONG;
                end
            end
            // full only survives the first ERR_WAIT cycle, giving one pulse
            ERR_WAIT: begin
                if (full) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_PARITY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RB_RW     <= 1'b1;
            RB_A      <= '0;
            RB_D      <= '0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            RB_RW     <= rw_nxt;
            RB_A      <= a_nxt;
            RB_D      <= d_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map  <= '0;
            done <= 1'b0;
        end else begin
            if (state == WRITE) map[frame[L-1 -: AW]] <= 1'b1;
            done <= done | (&map);
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: table vectors, reset corner, parity build,
// and random frames checked against a frame-level reference model.
module tb_serial_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sen0, sd0, sen1, sd1;
    logic rw0, done0, fe0;
    logic [2:0] a0;
    logic [17:0] d0;
    logic [1:0] ec0;
    logic rw1, done1, fe1;
    logic [3:0] a1;
    logic [7:0] d1;
    logic [1:0] ec1;

    serial_frame_rx #(.AW(3), .DW(18), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .sen(sen0), .sd(sd0),
        .RB_RW(rw0), .RB_A(a0), .RB_D(d0), .done(done0),
        .frame_err(fe0), .err_code(ec0)
    );

    serial_frame_rx #(.AW(4), .DW(8), .PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .sen(sen1), .sd(sd1),
        .RB_RW(rw1), .RB_A(a1), .RB_D(d1), .done(done1),
        .frame_err(fe1), .err_code(ec1)
    );

    typedef struct {
        int dut;
        int cyc;
        bit wr;
        int addr;
        int data;
        int code;
    } ev_t;

    typedef struct {
        int addr;
        int data;
        int n;
        int code;
        int done;
    } vec_t;

    ev_t evq[$];
    vec_t tab[20];
    int cyc = 0;
    int rise0 = -1;
    int rise1 = -1;
    int bank_c0[8];
    int bank_c1[16];
    logic pd0 = 1'b0;
    logic pd1 = 1'b0;
    int bank_m[2][16];
    bit cov[2][16];
    int ncmp = 0;
    int nbad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // bus monitor: one record per write cycle and per error pulse
    always @(negedge clk) begin
        if (rw0 === 1'b0) begin
            evq.push_back('{0, cyc, 1'b1, int'(a0), int'(d0), 0});
            bank_c0[a0] = int'(d0);
        end
        if (fe0 === 1'b1) evq.push_back('{0, cyc, 1'b0, 0, 0, int'(ec0)});
        if (rw1 === 1'b0) begin
            evq.push_back('{1, cyc, 1'b1, int'(a1), int'(d1), 0});
            bank_c1[a1] = int'(d1);
        end
        if (fe1 === 1'b1) evq.push_back('{1, cyc, 1'b0, 0, 0, int'(ec1)});
        if (done0 === 1'b1 && pd0 !== 1'b1) rise0 = cyc;
        if (done1 === 1'b1 && pd1 !== 1'b1) rise1 = cyc;
        pd0 = done0;
        pd1 = done1;
    end

    function automatic int lenof(input int d);
        return d != 0 ? 13 : 21;
    endfunction

    function automatic int awof(input int d);
        return d != 0 ? 4 : 3;
    endfunction

    function automatic int dwof(input int d);
        return d != 0 ? 8 : 18;
    endfunction

    function automatic int exp_code(input int n, input int len, input bit par, input bit flip);
        if (n < len) return 1;
        if (par && flip) return 3;
        if (n > len) return 2;
        return 0;
    endfunction

    function automatic logic [63:0] mkframe(input int d, input int addr, input int data,
                                            input bit flip);
        logic [63:0] v;
        logic p;
        v = (64'(addr) << dwof(d)) | 64'(data);
        p = ^v;
        if (d != 0) v = (v << 1) | 64'(p ^ flip);
        return v;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic put(input int d, input logic s, input logic b);
        if (d == 0) begin
            sen0 = s;
            sd0  = b;
        end else begin
            sen1 = s;
            sd1  = b;
        end
    endtask

    task automatic check_ev(input int d, input string tag, input bit wr, input int wcyc,
                            input int addr, input int data, input int code, input int ecyc);
        int nw = 0;
        int ne = 0;
        ev_t w;
        ev_t e;
        foreach (evq[i]) begin
            if (evq[i].dut == d) begin
                if (evq[i].wr) begin
                    nw++;
                    w = evq[i];
                end else begin
                    ne++;
                    e = evq[i];
                end
            end
        end
        evq.delete();
        cmp({tag, " writes"}, nw, int'(wr));
        if (wr && nw == 1) begin
            cmp({tag, " wcyc"}, w.cyc, wcyc);
            cmp({tag, " waddr"}, w.addr, addr);
            cmp({tag, " wdata"}, w.data, data);
        end
        cmp({tag, " errs"}, ne, int'(code != 0));
        if (code != 0 && ne == 1) begin
            cmp({tag, " ecode"}, e.code, code);
            cmp({tag, " ecyc"}, e.cyc, ecyc);
        end
    endtask

    task automatic run_frame(input int d, input int addr, input int data, input int n,
                             input bit flip, input int code, input int edone);
        int len;
        int t1;
        int tl;
        logic [63:0] v;
        bit wr;
        bit newc;
        bit all;
        string tag;
        len = lenof(d);
        t1 = 0;
        v = mkframe(d, addr, data, flip);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) t1 = cyc + 1;
            put(d, 1'b0, (k < len) ? v[len-1-k] : 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        put(d, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        tl = t1 + len - 1;
        wr = (code == 0) || (code == 2);
        newc = 1'b0;
        if (wr) begin
            bank_m[d][addr] = data;
            newc = !cov[d][addr];
            cov[d][addr] = 1'b1;
        end
        all = 1'b1;
        for (int i = 0; i < (1 << awof(d)); i++) all &= cov[d][i];
        tag = $sformatf("d%0d a%0h n%0d", d, addr, n);
        check_ev(d, tag, wr, tl + 1, addr, data, code, (code == 1) ? t1 + n : tl + 1);
        cmp({tag, " done"}, d != 0 ? int'(done1) : int'(done0), edone < 0 ? int'(all) : edone);
        if (wr && newc && all)
            cmp({tag, " done_rise"}, d != 0 ? rise1 : rise0, tl + 2);
    endtask

    task automatic chk_reset(input string tag);
        cmp({tag, " rw0"}, int'(rw0), 1);
        cmp({tag, " a0"}, int'(a0), 0);
        cmp({tag, " d0"}, int'(d0), 0);
        cmp({tag, " done0"}, int'(done0), 0);
        cmp({tag, " fe0"}, int'(fe0), 0);
        cmp({tag, " ec0"}, int'(ec0), 0);
        cmp({tag, " rw1"}, int'(rw1), 1);
        cmp({tag, " done1"}, int'(done1), 0);
        cmp({tag, " fe1"}, int'(fe1), 0);
    endtask

    task automatic chk_bank(input int d);
        for (int a = 0; a < (1 << awof(d)); a++) begin
            if (cov[d][a])
                cmp($sformatf("bank d%0d a%0h", d, a),
                    d != 0 ? bank_c1[a] : bank_c0[a], bank_m[d][a]);
        end
    endtask

    initial begin
        int pat[3];
        logic [63:0] v;
        int t1;
        pat[0] = 'h3FFFF;
        pat[1] = 'h00001;
        pat[2] = 'h2A5A5;
        for (int i = 0; i < 7; i++) tab[i] = '{i, pat[i % 3], 21, 0, 0};
        tab[7]  = '{3, 'h15A5A, 21, 0, 0};
        tab[8]  = '{7, 'h11111, 10, 1, 0};
        tab[9]  = '{1, 'h0BEEF, 21, 0, 0};
        tab[10] = '{2, 'h2AAAA, 22, 2, 0};
        tab[11] = '{7, 'h3FFFF, 21, 0, 1};
        for (int i = 0; i < 8; i++) tab[12 + i] = '{i, pat[i % 3], 21, 0, int'(i == 7)};

        rst = 1'b1;
        sen0 = 1'b1;
        sd0 = 1'b0;
        sen1 = 1'b1;
        sd1 = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        evq.delete();

        for (int i = 0; i < 12; i++)
            run_frame(0, tab[i].addr, tab[i].data, tab[i].n, 1'b0, tab[i].code, tab[i].done);
        chk_bank(0);

        // reset lands on bit 12; the tail of the frame then reads as a short frame
        v = mkframe(0, 5, 'h12345, 1'b0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            put(0, 1'b0, v[20-k]);
        end
        @(negedge clk);
        rst = 1'b1;
        put(0, 1'b0, v[8]);
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midrst");
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 16; a++) cov[d][a] = 1'b0;
        evq.delete();
        t1 = cyc + 1;
        put(0, 1'b0, v[7]);
        for (int k = 6; k >= 0; k--) begin
            @(negedge clk);
            put(0, 1'b0, v[k]);
        end
        @(negedge clk);
        put(0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check_ev(0, "tail", 1'b0, 0, 0, 0, 1, t1 + 8);
        cmp("tail done", int'(done0), 0);

        for (int i = 12; i < 20; i++)
            run_frame(0, tab[i].addr, tab[i].data, tab[i].n, 1'b0, tab[i].code, tab[i].done);
        chk_bank(0);

        run_frame(1, 5, 'h3C, 13, 1'b1, 3, 0);
        run_frame(1, 15, 'hC3, 13, 1'b0, 0, 0);
        chk_bank(1);

        for (int i = 0; i < 60; i++) begin
            int d;
            int len;
            int kind;
            int n;
            bit flip;
            int addr;
            int data;
            d = int'($urandom_range(0, 1));
            len = lenof(d);
            kind = int'($urandom_range(0, 9));
            n = kind < 6 ? len : kind < 8 ? int'($urandom_range(1, len - 1))
                                           : int'($urandom_range(len + 1, len + 4));
            flip = (d != 0) && ($urandom_range(0, 3) == 0);
            addr = int'($urandom_range(0, (1 << awof(d)) - 1));
            data = int'($urandom_range(0, (1 << dwof(d)) - 1));
            run_frame(d, addr, data, n, flip, exp_code(n, len, d != 0, flip), -1);
        end
        chk_bank(0);
        chk_bank(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
